// File: rtl/armleocpu_axi_arbiter2.sv
// Two-host AXI4 arbiter: grants one whole read or write transaction at a time,
// round-robin between hosts; lock/ID/payload pass through unchanged.
//
// state | meaning
// IDLE  | no grant; arbitrate between pending host requests
// READ  | granted host owns AR and R until the rlast beat handshakes
// WRITE | granted host owns AW, W and B until the B handshake
module armleocpu_axi_arbiter2 #(
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32,
   localparam int DATA_STROBES = DATA_WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    rst_n,

   input  logic                    host0_axi_awvalid,
   output logic                    host0_axi_awready,
   input  logic [ADDR_WIDTH-1:0]   host0_axi_awaddr,
   input  logic [7:0]              host0_axi_awlen,
   input  logic [2:0]              host0_axi_awsize,
   input  logic [1:0]              host0_axi_awburst,
   input  logic [ID_WIDTH-1:0]     host0_axi_awid,
   input  logic                    host0_axi_awlock,
   input  logic                    host0_axi_wvalid,
   output logic                    host0_axi_wready,
   input  logic [DATA_WIDTH-1:0]   host0_axi_wdata,
   input  logic [DATA_STROBES-1:0] host0_axi_wstrb,
   input  logic                    host0_axi_wlast,
   output logic                    host0_axi_bvalid,
   input  logic                    host0_axi_bready,
   output logic [1:0]              host0_axi_bresp,
   output logic [ID_WIDTH-1:0]     host0_axi_bid,
   input  logic                    host0_axi_arvalid,
   output logic                    host0_axi_arready,
   input  logic [ADDR_WIDTH-1:0]   host0_axi_araddr,
   input  logic [7:0]              host0_axi_arlen,
   input  logic [2:0]              host0_axi_arsize,
   input  logic [1:0]              host0_axi_arburst,
   input  logic [ID_WIDTH-1:0]     host0_axi_arid,
   input  logic                    host0_axi_arlock,
   output logic                    host0_axi_rvalid,
   input  logic                    host0_axi_rready,
   output logic [1:0]              host0_axi_rresp,
   output logic                    host0_axi_rlast,
   output logic [DATA_WIDTH-1:0]   host0_axi_rdata,
   output logic [ID_WIDTH-1:0]     host0_axi_rid,

   input  logic                    host1_axi_awvalid,
   output logic                    host1_axi_awready,
   input  logic [ADDR_WIDTH-1:0]   host1_axi_awaddr,
   input  logic [7:0]              host1_axi_awlen,
   input  logic [2:0]              host1_axi_awsize,
   input  logic [1:0]              host1_axi_awburst,
   input  logic [ID_WIDTH-1:0]     host1_axi_awid,
   input  logic                    host1_axi_awlock,
   input  logic                    host1_axi_wvalid,
   output logic                    host1_axi_wready,
   input  logic [DATA_WIDTH-1:0]   host1_axi_wdata,
   input  logic [DATA_STROBES-1:0] host1_axi_wstrb,
   input  logic                    host1_axi_wlast,
   output logic                    host1_axi_bvalid,
   input  logic                    host1_axi_bready,
   output logic [1:0]              host1_axi_bresp,
   output logic [ID_WIDTH-1:0]     host1_axi_bid,
   input  logic                    host1_axi_arvalid,
   output logic                    host1_axi_arready,
   input  logic [ADDR_WIDTH-1:0]   host1_axi_araddr,
   input  logic [7:0]              host1_axi_arlen,
   input  logic [2:0]              host1_axi_arsize,
   input  logic [1:0]              host1_axi_arburst,
   input  logic [ID_WIDTH-1:0]     host1_axi_arid,
   input  logic                    host1_axi_arlock,
   output logic                    host1_axi_rvalid,
   input  logic                    host1_axi_rready,
   output logic [1:0]              host1_axi_rresp,
   output logic                    host1_axi_rlast,
   output logic [DATA_WIDTH-1:0]   host1_axi_rdata,
   output logic [ID_WIDTH-1:0]     host1_axi_rid,

   output logic                    memory_axi_awvalid,
   input  logic                    memory_axi_awready,
   output logic [ADDR_WIDTH-1:0]   memory_axi_awaddr,
   output logic [7:0]              memory_axi_awlen,
   output logic [2:0]              memory_axi_awsize,
   output logic [1:0]              memory_axi_awburst,
   output logic [ID_WIDTH-1:0]     memory_axi_awid,
   output logic                    memory_axi_awlock,
   output logic                    memory_axi_wvalid,
   input  logic                    memory_axi_wready,
   output logic [DATA_WIDTH-1:0]   memory_axi_wdata,
   output logic [DATA_STROBES-1:0] memory_axi_wstrb,
   output logic                    memory_axi_wlast,
   input  logic                    memory_axi_bvalid,
   output logic                    memory_axi_bready,
   input  logic [1:0]              memory_axi_bresp,
   input  logic [ID_WIDTH-1:0]     memory_axi_bid,
   output logic                    memory_axi_arvalid,
   input  logic                    memory_axi_arready,
   output logic [ADDR_WIDTH-1:0]   memory_axi_araddr,
   output logic [7:0]              memory_axi_arlen,
   output logic [2:0]              memory_axi_arsize,
   output logic [1:0]              memory_axi_arburst,
   output logic [ID_WIDTH-1:0]     memory_axi_arid,
   output logic                    memory_axi_arlock,
   input  logic                    memory_axi_rvalid,
   output logic                    memory_axi_rready,
   input  logic [1:0]              memory_axi_rresp,
   input  logic                    memory_axi_rlast,
   input  logic [DATA_WIDTH-1:0]   memory_axi_rdata,
   input  logic [ID_WIDTH-1:0]     memory_axi_rid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   grant, grant_nxt;
   logic   last_grant, last_grant_nxt;
   logic   ar_done, ar_done_nxt;
   logic   aw_done, aw_done_nxt;
   logic   w_done, w_done_nxt;

   logic   req0, req1, winner;
   logic   sel_arvalid, sel_awvalid, sel_wvalid, sel_wlast, sel_rready, sel_bready;
   logic   sel_arready, sel_awready, sel_wready, sel_rvalid, sel_bvalid;

   assign req0 = host0_axi_arvalid | host0_axi_awvalid;
   assign req1 = host1_axi_arvalid | host1_axi_awvalid;

   assign sel_arvalid = grant ? host1_axi_arvalid : host0_axi_arvalid;
   assign sel_awvalid = grant ? host1_axi_awvalid : host0_axi_awvalid;
   assign sel_wvalid  = grant ? host1_axi_wvalid  : host0_axi_wvalid;
   assign sel_wlast   = grant ? host1_axi_wlast   : host0_axi_wlast;
   assign sel_rready  = grant ? host1_axi_rready  : host0_axi_rready;
   assign sel_bready  = grant ? host1_axi_bready  : host0_axi_bready;

   // Payloads follow the registered grant; only handshakes are gated by state.
   assign memory_axi_awaddr  = grant ? host1_axi_awaddr  : host0_axi_awaddr;
   assign memory_axi_awlen   = grant ? host1_axi_awlen   : host0_axi_awlen;
   assign memory_axi_awsize  = grant ? host1_axi_awsize  : host0_axi_awsize;
   assign memory_axi_awburst = grant ? host1_axi_awburst : host0_axi_awburst;
   assign memory_axi_awid    = grant ? host1_axi_awid    : host0_axi_awid;
   assign memory_axi_awlock  = grant ? host1_axi_awlock  : host0_axi_awlock;
   assign memory_axi_wdata   = grant ? host1_axi_wdata   : host0_axi_wdata;
   assign memory_axi_wstrb   = grant ? host1_axi_wstrb   : host0_axi_wstrb;
   assign memory_axi_wlast   = sel_wlast;
   assign memory_axi_araddr  = grant ? host1_axi_araddr  : host0_axi_araddr;
   assign memory_axi_arlen   = grant ? host1_axi_arlen   : host0_axi_arlen;
   assign memory_axi_arsize  = grant ? host1_axi_arsize  : host0_axi_arsize;
   assign memory_axi_arburst = grant ? host1_axi_arburst : host0_axi_arburst;
   assign memory_axi_arid    = grant ? host1_axi_arid    : host0_axi_arid;
   assign memory_axi_arlock  = grant ? host1_axi_arlock  : host0_axi_arlock;

   assign host0_axi_bresp = memory_axi_bresp;
   assign host0_axi_bid   = memory_axi_bid;
   assign host0_axi_rresp = memory_axi_rresp;
   assign host0_axi_rlast = memory_axi_rlast;
   assign host0_axi_rdata = memory_axi_rdata;
   assign host0_axi_rid   = memory_axi_rid;
   assign host1_axi_bresp = memory_axi_bresp;
   assign host1_axi_bid   = memory_axi_bid;
   assign host1_axi_rresp = memory_axi_rresp;
   assign host1_axi_rlast = memory_axi_rlast;
   assign host1_axi_rdata = memory_axi_rdata;
   assign host1_axi_rid   = memory_axi_rid;

   assign host0_axi_arready = ~grant & sel_arready;
   assign host0_axi_awready = ~grant & sel_awready;
   assign host0_axi_wready  = ~grant & sel_wready;
   assign host0_axi_rvalid  = ~grant & sel_rvalid;
   assign host0_axi_bvalid  = ~grant & sel_bvalid;
   assign host1_axi_arready =  grant & sel_arready;
   assign host1_axi_awready =  grant & sel_awready;
   assign host1_axi_wready  =  grant & sel_wready;
   assign host1_axi_rvalid  =  grant & sel_rvalid;
   assign host1_axi_bvalid  =  grant & sel_bvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         ar_done    <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         ar_done    <= ar_done_nxt;
         aw_done    <= aw_done_nxt;
         w_done     <= w_done_nxt;
      end
   end

   always_comb begin
      state_nxt          = state;
      grant_nxt          = grant;
      last_grant_nxt     = last_grant;
      ar_done_nxt        = ar_done;
      aw_done_nxt        = aw_done;
      w_done_nxt         = w_done;
      winner             = 1'b0;
      memory_axi_arvalid = 1'b0;
      memory_axi_awvalid = 1'b0;
      memory_axi_wvalid  = 1'b0;
      memory_axi_rready  = 1'b0;
      memory_axi_bready  = 1'b0;
      sel_arready        = 1'b0;
      sel_awready        = 1'b0;
      sel_wready         = 1'b0;
      sel_rvalid         = 1'b0;
      sel_bvalid         = 1'b0;

      case (state)
         IDLE: begin
            if (req0 | req1) begin
               winner         = (req0 & req1) ? ~last_grant : req1;
               grant_nxt      = winner;
               last_grant_nxt = winner;
               ar_done_nxt    = 1'b0;
               aw_done_nxt    = 1'b0;
               w_done_nxt     = 1'b0;
               // A read wins over a simultaneous write from the same host.
               if (winner ? host1_axi_arvalid : host0_axi_arvalid)
                  state_nxt = READ;
               else
                  state_nxt = WRITE;
            end
         end

         READ: begin
            memory_axi_arvalid = sel_arvalid & ~ar_done;
            sel_arready        = memory_axi_arready & ~ar_done;
            if (memory_axi_arvalid & memory_axi_arready)
               ar_done_nxt = 1'b1;
            sel_rvalid         = memory_axi_rvalid;
            memory_axi_rready  = sel_rready;
            if (memory_axi_rvalid & sel_rready & memory_axi_rlast)
               state_nxt = IDLE;
         end

         WRITE: begin
            memory_axi_awvalid = sel_awvalid & ~aw_done;
            sel_awready        = memory_axi_awready & ~aw_done;
            if (memory_axi_awvalid & memory_axi_awready)
               aw_done_nxt = 1'b1;
            memory_axi_wvalid  = sel_wvalid & ~w_done;
            sel_wready         = memory_axi_wready & ~w_done;
            if (memory_axi_wvalid & memory_axi_wready & sel_wlast)
               w_done_nxt = 1'b1;
            // The response is only meaningful once address and data have both left.
            if (aw_done & w_done) begin
               sel_bvalid        = memory_axi_bvalid;
               memory_axi_bready = sel_bready;
               if (memory_axi_bvalid & sel_bready)
                  state_nxt = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_armleocpu_axi_arbiter2.sv
// Directed testbench for armleocpu_axi_arbiter2: bench drives both hosts and
// plays the downstream memory, checking forwarded signals cycle by cycle.
module tb_armleocpu_axi_arbiter2;
   localparam int AW = 32;
   localparam int IW = 4;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          h0_awvalid, h0_awready, h0_awlock, h0_wvalid, h0_wready, h0_wlast;
   logic [AW-1:0] h0_awaddr, h0_araddr;
   logic [7:0]    h0_awlen, h0_arlen;
   logic [2:0]    h0_awsize, h0_arsize;
   logic [1:0]    h0_awburst, h0_arburst, h0_bresp, h0_rresp;
   logic [IW-1:0] h0_awid, h0_arid, h0_bid, h0_rid;
   logic [DW-1:0] h0_wdata, h0_rdata;
   logic [SW-1:0] h0_wstrb;
   logic          h0_bvalid, h0_bready, h0_arvalid, h0_arready, h0_arlock;
   logic          h0_rvalid, h0_rready, h0_rlast;

   logic          h1_awvalid, h1_awready, h1_awlock, h1_wvalid, h1_wready, h1_wlast;
   logic [AW-1:0] h1_awaddr, h1_araddr;
   logic [7:0]    h1_awlen, h1_arlen;
   logic [2:0]    h1_awsize, h1_arsize;
   logic [1:0]    h1_awburst, h1_arburst, h1_bresp, h1_rresp;
   logic [IW-1:0] h1_awid, h1_arid, h1_bid, h1_rid;
   logic [DW-1:0] h1_wdata, h1_rdata;
   logic [SW-1:0] h1_wstrb;
   logic          h1_bvalid, h1_bready, h1_arvalid, h1_arready, h1_arlock;
   logic          h1_rvalid, h1_rready, h1_rlast;

   logic          m_awvalid, m_awready, m_awlock, m_wvalid, m_wready, m_wlast;
   logic [AW-1:0] m_awaddr, m_araddr;
   logic [7:0]    m_awlen, m_arlen;
   logic [2:0]    m_awsize, m_arsize;
   logic [1:0]    m_awburst, m_arburst, m_bresp, m_rresp;
   logic [IW-1:0] m_awid, m_arid, m_bid, m_rid;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [SW-1:0] m_wstrb;
   logic          m_bvalid, m_bready, m_arvalid, m_arready, m_arlock;
   logic          m_rvalid, m_rready, m_rlast;

   int checks = 0;
   int errors = 0;

   armleocpu_axi_arbiter2 #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .host0_axi_awvalid(h0_awvalid), .host0_axi_awready(h0_awready), .host0_axi_awaddr(h0_awaddr),
      .host0_axi_awlen(h0_awlen), .host0_axi_awsize(h0_awsize), .host0_axi_awburst(h0_awburst),
      .host0_axi_awid(h0_awid), .host0_axi_awlock(h0_awlock),
      .host0_axi_wvalid(h0_wvalid), .host0_axi_wready(h0_wready), .host0_axi_wdata(h0_wdata),
      .host0_axi_wstrb(h0_wstrb), .host0_axi_wlast(h0_wlast),
      .host0_axi_bvalid(h0_bvalid), .host0_axi_bready(h0_bready), .host0_axi_bresp(h0_bresp),
      .host0_axi_bid(h0_bid),
      .host0_axi_arvalid(h0_arvalid), .host0_axi_arready(h0_arready), .host0_axi_araddr(h0_araddr),
      .host0_axi_arlen(h0_arlen), .host0_axi_arsize(h0_arsize), .host0_axi_arburst(h0_arburst),
      .host0_axi_arid(h0_arid), .host0_axi_arlock(h0_arlock),
      .host0_axi_rvalid(h0_rvalid), .host0_axi_rready(h0_rready), .host0_axi_rresp(h0_rresp),
      .host0_axi_rlast(h0_rlast), .host0_axi_rdata(h0_rdata), .host0_axi_rid(h0_rid),
      .host1_axi_awvalid(h1_awvalid), .host1_axi_awready(h1_awready), .host1_axi_awaddr(h1_awaddr),
      .host1_axi_awlen(h1_awlen), .host1_axi_awsize(h1_awsize), .host1_axi_awburst(h1_awburst),
      .host1_axi_awid(h1_awid), .host1_axi_awlock(h1_awlock),
      .host1_axi_wvalid(h1_wvalid), .host1_axi_wready(h1_wready), .host1_axi_wdata(h1_wdata),
      .host1_axi_wstrb(h1_wstrb), .host1_axi_wlast(h1_wlast),
      .host1_axi_bvalid(h1_bvalid), .host1_axi_bready(h1_bready), .host1_axi_bresp(h1_bresp),
      .host1_axi_bid(h1_bid),
      .host1_axi_arvalid(h1_arvalid), .host1_axi_arready(h1_arready), .host1_axi_araddr(h1_araddr),
      .host1_axi_arlen(h1_arlen), .host1_axi_arsize(h1_arsize), .host1_axi_arburst(h1_arburst),
      .host1_axi_arid(h1_arid), .host1_axi_arlock(h1_arlock),
      .host1_axi_rvalid(h1_rvalid), .host1_axi_rready(h1_rready), .host1_axi_rresp(h1_rresp),
      .host1_axi_rlast(h1_rlast), .host1_axi_rdata(h1_rdata), .host1_axi_rid(h1_rid),
      .memory_axi_awvalid(m_awvalid), .memory_axi_awready(m_awready), .memory_axi_awaddr(m_awaddr),
      .memory_axi_awlen(m_awlen), .memory_axi_awsize(m_awsize), .memory_axi_awburst(m_awburst),
      .memory_axi_awid(m_awid), .memory_axi_awlock(m_awlock),
      .memory_axi_wvalid(m_wvalid), .memory_axi_wready(m_wready), .memory_axi_wdata(m_wdata),
      .memory_axi_wstrb(m_wstrb), .memory_axi_wlast(m_wlast),
      .memory_axi_bvalid(m_bvalid), .memory_axi_bready(m_bready), .memory_axi_bresp(m_bresp),
      .memory_axi_bid(m_bid),
      .memory_axi_arvalid(m_arvalid), .memory_axi_arready(m_arready), .memory_axi_araddr(m_araddr),
      .memory_axi_arlen(m_arlen), .memory_axi_arsize(m_arsize), .memory_axi_arburst(m_arburst),
      .memory_axi_arid(m_arid), .memory_axi_arlock(m_arlock),
      .memory_axi_rvalid(m_rvalid), .memory_axi_rready(m_rready), .memory_axi_rresp(m_rresp),
      .memory_axi_rlast(m_rlast), .memory_axi_rdata(m_rdata), .memory_axi_rid(m_rid)
   );

   task automatic clear_inputs();
      h0_awvalid = 0; h0_awaddr = '0; h0_awlen = '0; h0_awsize = 3'd2; h0_awburst = 2'd1;
      h0_awid = '0; h0_awlock = 0; h0_wvalid = 0; h0_wdata = '0; h0_wstrb = '0; h0_wlast = 0;
      h0_bready = 0; h0_arvalid = 0; h0_araddr = '0; h0_arlen = '0; h0_arsize = 3'd2;
      h0_arburst = 2'd1; h0_arid = '0; h0_arlock = 0; h0_rready = 0;
      h1_awvalid = 0; h1_awaddr = '0; h1_awlen = '0; h1_awsize = 3'd2; h1_awburst = 2'd1;
      h1_awid = '0; h1_awlock = 0; h1_wvalid = 0; h1_wdata = '0; h1_wstrb = '0; h1_wlast = 0;
      h1_bready = 0; h1_arvalid = 0; h1_araddr = '0; h1_arlen = '0; h1_arsize = 3'd2;
      h1_arburst = 2'd1; h1_arid = '0; h1_arlock = 0; h1_rready = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0; m_bid = '0;
      m_arready = 0; m_rvalid = 0; m_rresp = '0; m_rlast = 0; m_rdata = '0; m_rid = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_inputs();
      @(posedge clk);
      #2;
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      h0_arvalid = 1; h1_awvalid = 1; h0_rready = 1; h1_bready = 1;
      m_arready = 1; m_awready = 1; m_wready = 1; m_rvalid = 1; m_bvalid = 1;
      tick();
      #1;
      checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_m_arvalid got %b exp 0", m_arvalid); end
      checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL reset_m_awvalid got %b exp 0", m_awvalid); end
      checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL reset_m_rready got %b exp 0", m_rready); end
      checks++; if (m_bready !== 1'b0) begin errors++; $display("FAIL reset_m_bready got %b exp 0", m_bready); end
      checks++; if (h0_arready !== 1'b0) begin errors++; $display("FAIL reset_h0_arready got %b exp 0", h0_arready); end
      checks++; if (h0_rvalid !== 1'b0 || h1_bvalid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b%b exp 00", h0_rvalid, h1_bvalid); end
      clear_inputs();
      rst_n = 1;
      tick();
   endtask

   task automatic test_single_read();
      clear_inputs();
      h1_arvalid = 1; h1_araddr = 32'h100; h1_arlen = 8'd0; h1_arid = 4'd5;
      #1;
      checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL read_idle_arvalid got %b exp 0", m_arvalid); end
      tick();
      m_arready = 1;
      #1;
      checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h100 || m_arid !== 4'd5) begin errors++; $display("FAIL read_ar_fwd got v=%b a=%h id=%h exp v=1 a=100 id=5", m_arvalid, m_araddr, m_arid); end
      checks++; if (h1_arready !== 1'b1 || h0_arready !== 1'b0) begin errors++; $display("FAIL read_arready got h1=%b h0=%b exp 1 0", h1_arready, h0_arready); end
      tick();
      m_arready = 0;
      m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rlast = 1; m_rid = 4'd5; h1_rready = 1;
      #1;
      checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL read_ar_done got %b exp 0", m_arvalid); end
      checks++; if (h1_rvalid !== 1'b1 || h1_rdata !== 32'hDEADBEEF || h1_rid !== 4'd5 || h1_rlast !== 1'b1) begin errors++; $display("FAIL read_r_fwd got v=%b d=%h id=%h l=%b", h1_rvalid, h1_rdata, h1_rid, h1_rlast); end
      checks++; if (h0_rvalid !== 1'b0 || m_rready !== 1'b1) begin errors++; $display("FAIL read_r_route got h0_rvalid=%b m_rready=%b exp 0 1", h0_rvalid, m_rready); end
      h1_arvalid = 0;
      tick();
      #1;
      checks++; if (h1_rvalid !== 1'b0 || m_rready !== 1'b0) begin errors++; $display("FAIL read_back_idle got rvalid=%b rready=%b exp 0 0", h1_rvalid, m_rready); end
      clear_inputs();
   endtask

   task automatic test_tie_fairness();
      logic [IW-1:0] exp_id;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         h0_arvalid = 1; h0_arid = 4'hA; h1_arvalid = 1; h1_arid = 4'hB;
         h0_rready = 1; h1_rready = 1; m_arready = 1;
         exp_id = (i % 2 == 0) ? 4'hA : 4'hB;
         tick();
         #1;
         checks++; if (m_arid !== exp_id) begin errors++; $display("FAIL tie_grant_%0d got id=%h exp %h", i, m_arid, exp_id); end
         checks++;
         if ((i % 2 == 0 && h1_arready !== 1'b0) || (i % 2 == 1 && h0_arready !== 1'b0)) begin
            errors++; $display("FAIL tie_loser_arready_%0d got h0=%b h1=%b", i, h0_arready, h1_arready);
         end
         tick();
         m_rvalid = 1; m_rlast = 1; m_rid = exp_id; m_rdata = 32'h55;
         #1;
         checks++;
         if ((i % 2 == 0 && h1_rvalid !== 1'b0) || (i % 2 == 1 && h0_rvalid !== 1'b0)) begin
            errors++; $display("FAIL tie_loser_rvalid_%0d got h0=%b h1=%b", i, h0_rvalid, h1_rvalid);
         end
         tick();
         m_rvalid = 0; m_rlast = 0;
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_write_w_first();
      clear_inputs();
      h0_wvalid = 1; h0_wlast = 1; h0_wdata = 32'h12345678; h0_wstrb = 4'hF;
      m_wready = 1;
      #1;
      checks++; if (m_wvalid !== 1'b0 || h0_wready !== 1'b0) begin errors++; $display("FAIL wr_w_no_grant got wvalid=%b wready=%b exp 0 0", m_wvalid, h0_wready); end
      tick();
      tick();
      h0_awvalid = 1; h0_awaddr = 32'h80; h0_awid = 4'd2;
      tick();
      #1;
      checks++; if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_wdata !== 32'h12345678 || m_wstrb !== 4'hF) begin errors++; $display("FAIL wr_fwd got awv=%b wv=%b d=%h s=%h", m_awvalid, m_wvalid, m_wdata, m_wstrb); end
      checks++; if (h0_wready !== 1'b1 || h1_wready !== 1'b0 || h0_awready !== 1'b0) begin errors++; $display("FAIL wr_w_ready got h0w=%b h1w=%b h0aw=%b exp 1 0 0", h0_wready, h1_wready, h0_awready); end
      tick();
      m_bvalid = 1; m_bresp = 2'b00; m_bid = 4'd2; h0_bready = 1; m_awready = 1;
      #1;
      checks++; if (m_wvalid !== 1'b0 || h0_wready !== 1'b0) begin errors++; $display("FAIL wr_w_done got wvalid=%b wready=%b exp 0 0", m_wvalid, h0_wready); end
      checks++; if (h0_bvalid !== 1'b0 || m_bready !== 1'b0) begin errors++; $display("FAIL wr_b_early got bvalid=%b bready=%b exp 0 0", h0_bvalid, m_bready); end
      checks++; if (h0_awready !== 1'b1 || m_awaddr !== 32'h80) begin errors++; $display("FAIL wr_aw got awready=%b addr=%h exp 1 80", h0_awready, m_awaddr); end
      tick();
      h0_awvalid = 0; h0_wvalid = 0; m_awready = 0; m_wready = 0;
      #1;
      checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL wr_aw_done got %b exp 0", m_awvalid); end
      checks++; if (h0_bvalid !== 1'b1 || h0_bresp !== 2'b00 || h0_bid !== 4'd2 || m_bready !== 1'b1) begin errors++; $display("FAIL wr_b_fwd got v=%b r=%b id=%h rdy=%b", h0_bvalid, h0_bresp, h0_bid, m_bready); end
      checks++; if (h1_bvalid !== 1'b0) begin errors++; $display("FAIL wr_h1_bvalid got %b exp 0", h1_bvalid); end
      tick();
      #1;
      checks++; if (h0_bvalid !== 1'b0 || m_bready !== 1'b0) begin errors++; $display("FAIL wr_back_idle got bvalid=%b bready=%b exp 0 0", h0_bvalid, m_bready); end
      clear_inputs();
   endtask

   task automatic test_burst_read();
      int beat;
      int cyc;
      clear_inputs();
      h0_arvalid = 1; h0_araddr = 32'h200; h0_arlen = 8'd3; h0_arid = 4'd3;
      tick();
      m_arready = 1;
      tick();
      h0_arvalid = 0; m_arready = 0;
      beat = 0;
      cyc = 0;
      while (beat < 4 && cyc < 16) begin
         m_rvalid = 1; m_rdata = 32'hA0 + beat; m_rlast = (beat == 3); m_rid = 4'd3;
         h0_rready = cyc[0];
         #1;
         checks++; if (h0_rvalid !== 1'b1 || m_rready !== h0_rready) begin errors++; $display("FAIL burst_active_c%0d got rvalid=%b rready=%b", cyc, h0_rvalid, m_rready); end
         if (h0_rready) begin
            checks++; if (h0_rdata !== 32'hA0 + beat || h0_rlast !== (beat == 3)) begin errors++; $display("FAIL burst_beat_%0d got d=%h l=%b", beat, h0_rdata, h0_rlast); end
         end
         tick();
         if (h0_rready) beat++;
         cyc++;
      end
      checks++; if (beat != 4) begin errors++; $display("FAIL burst_count got %0d exp 4", beat); end
      h0_rready = 1;
      #1;
      checks++; if (h0_rvalid !== 1'b0 || m_rready !== 1'b0) begin errors++; $display("FAIL burst_back_idle got rvalid=%b rready=%b exp 0 0", h0_rvalid, m_rready); end
      clear_inputs();
   endtask

   task automatic test_lock_passthrough();
      clear_inputs();
      h1_arvalid = 1; h1_arlock = 1; h1_araddr = 32'h40; h1_arid = 4'd7;
      tick();
      m_arready = 1;
      #1;
      checks++; if (m_arvalid !== 1'b1 || m_arlock !== 1'b1 || m_araddr !== 32'h40 || h1_arready !== 1'b1) begin errors++; $display("FAIL lock_ar got v=%b lock=%b a=%h rdy=%b", m_arvalid, m_arlock, m_araddr, h1_arready); end
      tick();
      h1_arvalid = 0; h1_arlock = 0; m_arready = 0;
      m_rvalid = 1; m_rresp = 2'b01; m_rlast = 1; m_rid = 4'd7; h1_rready = 1;
      #1;
      checks++; if (h1_rvalid !== 1'b1 || h1_rresp !== 2'b01 || h1_rid !== 4'd7) begin errors++; $display("FAIL lock_r_exokay got v=%b resp=%b id=%h", h1_rvalid, h1_rresp, h1_rid); end
      tick();
      clear_inputs();
      h1_awvalid = 1; h1_awlock = 1; h1_awaddr = 32'h40; h1_awid = 4'd7;
      h1_wvalid = 1; h1_wlast = 1; h1_wdata = 32'hCAFE; h1_wstrb = 4'hF;
      m_awready = 1; m_wready = 1;
      tick();
      #1;
      checks++; if (m_awlock !== 1'b1 || m_awaddr !== 32'h40 || h1_awready !== 1'b1 || h1_wready !== 1'b1) begin errors++; $display("FAIL lock_aw got lock=%b a=%h awr=%b wr=%b", m_awlock, m_awaddr, h1_awready, h1_wready); end
      tick();
      h1_awvalid = 0; h1_wvalid = 0; m_awready = 0; m_wready = 0;
      m_bvalid = 1; m_bresp = 2'b01; m_bid = 4'd7; h1_bready = 1;
      #1;
      checks++; if (h1_bvalid !== 1'b1 || h1_bresp !== 2'b01 || h0_bvalid !== 1'b0) begin errors++; $display("FAIL lock_b_exokay got v1=%b resp=%b v0=%b", h1_bvalid, h1_bresp, h0_bvalid); end
      tick();
      clear_inputs();
   endtask

   task automatic test_mid_write_reset();
      clear_inputs();
      h0_awvalid = 1; h0_awaddr = 32'h90; h0_wvalid = 1; h0_wlast = 1; h0_wdata = 32'h1;
      tick();
      m_awready = 1;
      tick();
      h0_awvalid = 0; m_awready = 0; m_wready = 1;
      #1;
      checks++; if (m_wvalid !== 1'b1 || h0_wready !== 1'b1) begin errors++; $display("FAIL rst_pre_w got wvalid=%b wready=%b exp 1 1", m_wvalid, h0_wready); end
      #1;
      rst_n = 0;
      #1;
      checks++; if (m_wvalid !== 1'b0 || h0_wready !== 1'b0 || m_awvalid !== 1'b0 || m_bready !== 1'b0) begin errors++; $display("FAIL rst_async got wv=%b wr=%b awv=%b br=%b exp 0", m_wvalid, h0_wready, m_awvalid, m_bready); end
      clear_inputs();
      #2;
      rst_n = 1;
      h0_arvalid = 1; h0_arid = 4'd1; h1_arvalid = 1; h1_arid = 4'd9; m_arready = 1;
      tick();
      #1;
      checks++; if (m_arid !== 4'd1 || h1_arready !== 1'b0 || h0_arready !== 1'b1) begin errors++; $display("FAIL rst_first_tie got id=%h h0r=%b h1r=%b exp 1 1 0", m_arid, h0_arready, h1_arready); end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_tie_fairness();
      test_write_w_first();
      test_burst_read();
      test_lock_passthrough();
      test_mid_write_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
